sram_controller: RTL and testbench

- Sequences the external 128 KiB byte-wide asynchronous SRAM that is mapped at 0x9000–0x28FFF.
- Takes single access requests from the load/store unit through a trigger/busy handshake.
- Splits byte, short and word accesses into 1, 2 or 4 little-endian byte cycles with programmable strobe timing.
- Returns the assembled read word and pulses completion.

---
 rtl/sram_controller_if.sv | 34 +++
 rtl/sram_controller.sv | 199 +++++++++++++++++++
 tb/tb_sram_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
// Request/response bus between the load/store unit and sram_controller.
//   trigger     request strobe (LSU -> controller)
//   we          1 = write, 0 = read
//   data_width  00 byte, 01 short, 10/11 word
//   addr        CPU byte address
//   write_data  store data, byte 0 goes out first
//   busy        transfer in progress (controller -> LSU)
//   done        one-cycle completion pulse
//   err         one-cycle pulse with done when addr missed the SRAM window
//   read_data   assembled little-endian load data, zero-extended
// ---------------------------------------------------------------------------
interface sram_controller_if;
   logic        trigger;
   logic        we;
   logic [1:0]  data_width;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] read_data;

   modport master (
      output trigger, we, data_width, addr, write_data,
      input  busy, done, err, read_data
   );

   modport slave (
      input  trigger, we, data_width, addr, write_data,
      output busy, done, err, read_data
   );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Sequences a byte-wide asynchronous SRAM mapped at ADDR_BASE. A single
// request (byte/short/word) is split into 1/2/4 sequential little-endian byte
// cycles of SETUP (1) + STROBE (WAIT_CYCLES) + HOLD (1) clocks each.
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   bus         LSU request/response bus (slave side)
//   sram_addr   SRAM byte address
//   sram_dq_o   write data to the pads
//   sram_dq_i   read data from the pads
//   sram_dq_oe  pad output enable
//   sram_ce_n   chip enable, active-low
//   sram_oe_n   output enable, active-low
//   sram_we_n   write enable, active-low
// All pin and status outputs come straight from flops so the SRAM strobes
// are glitch-free and drop to their inactive level the moment rst falls.
// ---------------------------------------------------------------------------
module sram_controller #(
   parameter logic [31:0] ADDR_BASE   = 32'h9000,
   parameter int          SRAM_AW     = 17,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [7:0]         sram_dq_o,
   input  logic [7:0]         sram_dq_i,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   localparam logic [3:0]         WAIT_INIT = 4'(WAIT_CYCLES - 1);
   localparam logic [SRAM_AW-1:0] OFF_ONE   = {{(SRAM_AW-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic               err_q, err_d;          // pending error for the DONE cycle
   logic               armed_q, armed_d;      // trigger has been seen low since last acceptance
   logic [2:0]         bytes_left_q, bytes_left_d;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [3:0]         wait_q, wait_d;
   logic [SRAM_AW-1:0] offset_q, offset_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic               dq_oe_q, dq_oe_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_out_q, err_out_d;
   logic               active_d;

   logic [31:0]        rel_addr;
   logic               in_range;

   assign rel_addr = bus.addr - ADDR_BASE;
   assign in_range = (bus.addr >= ADDR_BASE) && ((rel_addr >> SRAM_AW) == 32'd0);

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned -- otherwise synthesis infers a latch.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      err_d        = err_q;
      bytes_left_d = bytes_left_q;
      byte_idx_d   = byte_idx_q;
      wait_d       = wait_q;
      offset_d     = offset_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      // A level held across a whole transfer must not start a second one,
      // so acceptance needs trigger to have dropped since the last one.
      armed_d      = armed_q | ~bus.trigger;

      unique case (state_q)
         IDLE: begin
            if (bus.trigger && armed_q) begin
               armed_d    = 1'b0;
               we_d       = bus.we;
               rdata_d    = '0;
               byte_idx_d = 2'd0;
               unique case (bus.data_width)
                  2'b00:   bytes_left_d = 3'd1;
                  2'b01:   bytes_left_d = 3'd2;
                  default: bytes_left_d = 3'd4;
               endcase
               if (in_range) begin
                  // Only a valid request touches the pin-facing registers.
                  err_d    = 1'b0;
                  offset_d = rel_addr[SRAM_AW-1:0];
                  if (bus.we) wdata_d = bus.write_data;
                  state_d  = SETUP;
               end else begin
                  err_d    = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         SETUP: begin
            wait_d  = WAIT_INIT;
            state_d = STROBE;
         end
         STROBE: begin
            if (wait_q == 4'd0) begin
               // Last strobe cycle: oe_n is still low, so the pads are valid.
               if (!we_q) rdata_d[{byte_idx_q, 3'b000} +: 8] = sram_dq_i;
               state_d = HOLD;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         HOLD: begin
            if (bytes_left_q > 3'd1) begin
               bytes_left_d = bytes_left_q - 3'd1;
               byte_idx_d   = byte_idx_q + 2'd1;
               offset_d     = offset_q + OFF_ONE;   // wraps silently at the top
               wdata_d      = {8'h00, wdata_q[31:8]};
               state_d      = SETUP;
            end else begin
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pin and status values for the coming cycle, decoded from next state.
      active_d  = state_d inside {SETUP, STROBE, HOLD};
      ce_n_d    = ~active_d;
      oe_n_d    = ~((state_d == STROBE) && !we_d);
      we_n_d    = ~((state_d == STROBE) && we_d);
      dq_oe_d   = active_d && we_d;
      busy_d    = active_d;
      done_d    = (state_d == DONE);
      err_out_d = (state_d == DONE) && err_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         armed_q      <= 1'b1;
         bytes_left_q <= 3'd0;
         byte_idx_q   <= 2'd0;
         wait_q       <= 4'd0;
         offset_q     <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         dq_oe_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_out_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         err_q        <= err_d;
         armed_q      <= armed_d;
         bytes_left_q <= bytes_left_d;
         byte_idx_q   <= byte_idx_d;
         wait_q       <= wait_d;
         offset_q     <= offset_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         dq_oe_q      <= dq_oe_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_out_q    <= err_out_d;
      end
   end

   assign sram_addr     = offset_q;
   assign sram_dq_o     = wdata_q[7:0];
   assign sram_dq_oe    = dq_oe_q;
   assign sram_ce_n     = ce_n_q;
   assign sram_oe_n     = oe_n_q;
   assign sram_we_n     = we_n_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_out_q;
   assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
// Directed bench for sram_controller (ADDR_BASE 0x9000, SRAM_AW 17,
// WAIT_CYCLES 2). A behavioural SRAM model stores bytes written under
// we_n/ce_n and returns a fixed pattern for locations never written.
// ---------------------------------------------------------------------------
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [16:0] sram_addr;
   logic [7:0]  sram_dq_o;
   logic [7:0]  sram_dq_i;
   logic        sram_dq_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   int checks   = 0;
   int failures = 0;

   sram_controller_if bus ();

   sram_controller #(
      .ADDR_BASE   (32'h9000),
      .SRAM_AW     (17),
      .WAIT_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_i  (sram_dq_i),
      .sram_dq_oe (sram_dq_oe),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM model and pin monitor ----------------
   logic [7:0] mem    [0:131071];
   bit         wvalid [0:131071];

   function automatic logic [7:0] model_byte(input logic [16:0] a);
      if (wvalid[a]) return mem[a];
      case (a)
         17'h00005: return 8'h8F;
         17'h1FFFF: return 8'h3C;
         17'h00000: return 8'h7E;
         default:   return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? model_byte(sram_addr) : 8'h5A;

   int         mon_ce_falls  = 0;
   int         mon_done      = 0;
   int         mon_overlap   = 0;
   int         mon_dq_oe     = 0;
   int         mon_we_pulses = 0;
   int         cur_w         = 0;
   logic       prev_we_n     = 1'b1;
   logic       prev_ce_n     = 1'b1;
   logic       prev_oe_n     = 1'b1;
   int         wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   int         we_width_q[$];
   int         rd_addr_q[$];

   always @(negedge clk) begin
      if (!sram_ce_n && prev_ce_n) mon_ce_falls <= mon_ce_falls + 1;
      if (bus.done)                mon_done     <= mon_done + 1;
      if (sram_dq_oe && !sram_oe_n) mon_overlap <= mon_overlap + 1;
      if (sram_dq_oe)              mon_dq_oe    <= mon_dq_oe + 1;
      if (!sram_oe_n && prev_oe_n) rd_addr_q.push_back(int'(sram_addr));
      if (!sram_we_n) begin
         if (prev_we_n) begin
            mon_we_pulses <= mon_we_pulses + 1;
            wr_addr_q.push_back(int'(sram_addr));
            wr_data_q.push_back(sram_dq_o);
            cur_w <= 1;
         end else begin
            cur_w <= cur_w + 1;
         end
         if (!sram_ce_n) begin
            mem[sram_addr]    <= sram_dq_o;
            wvalid[sram_addr] <= 1'b1;
         end
      end else if (!prev_we_n) begin
         we_width_q.push_back(cur_w);
      end
      prev_we_n <= sram_we_n;
      prev_ce_n <= sram_ce_n;
      prev_oe_n <= sram_oe_n;
   end

   // ---------------- transaction driver ----------------
   // Trigger is raised in cycle 0; lat is the cycle index at which done is
   // seen (-1 if it never comes).
   task automatic do_xfer(input logic wr, input logic [1:0] dw, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic e);
      @(negedge clk);
      bus.trigger    = 1'b1;
      bus.we         = wr;
      bus.data_width = dw;
      bus.addr       = a;
      bus.write_data = wd;
      lat = -1;
      rd  = 32'hDEAD_BEEF;
      e   = 1'bx;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         bus.trigger = 1'b0;
         if (bus.done) begin
            lat = c;
            rd  = bus.read_data;
            e   = bus.err;
            break;
         end
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.err, sram_dq_oe} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_status: busy/done/err/dq_oe=%b expected 0000", {bus.busy, bus.done, bus.err, sram_dq_oe});
      end
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
         failures++;
         $display("FAIL reset_strobes: ce/oe/we_n=%b expected 111", {sram_ce_n, sram_oe_n, sram_we_n});
      end
      checks++;
      if (bus.read_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_read_data: got %h expected 00000000", bus.read_data);
      end
      checks++;
      if ({sram_addr, sram_dq_o} !== 25'h0) begin
         failures++;
         $display("FAIL reset_addr_data: addr=%h dq_o=%h expected 0/0", sram_addr, sram_dq_o);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_word_write;
      int lat; logic [31:0] rd; logic e;
      int wb, ww, cb, ob, n;
      logic [31:0] wd;
      wd = 32'hA1B2C3D4;
      wb = wr_addr_q.size(); ww = we_width_q.size(); cb = mon_ce_falls; ob = mon_overlap;
      do_xfer(1'b1, 2'b10, 32'h9010, wd, lat, rd, e);
      checks++;
      if (lat !== 17) begin failures++; $display("FAIL word_write_latency: got %0d expected 17", lat); end
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL word_write_err: got %b expected 0", e); end
      n = wr_addr_q.size() - wb;
      checks++;
      if (n !== 4) begin failures++; $display("FAIL word_write_pulses: got %0d expected 4", n); end
      if (n == 4 && we_width_q.size() - ww == 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_q[wb+i] !== 32'h10 + i || wr_data_q[wb+i] !== wd[8*i +: 8] || we_width_q[ww+i] !== 2) begin
               failures++;
               $display("FAIL word_write_byte%0d: addr=%h data=%h width=%0d expected addr=%h data=%h width=2",
                        i, wr_addr_q[wb+i], wr_data_q[wb+i], we_width_q[ww+i], 32'h10 + i, wd[8*i +: 8]);
            end
         end
      end
      checks++;
      if (mon_ce_falls - cb !== 1) begin failures++; $display("FAIL word_write_ce_continuous: ce_n falls=%0d expected 1", mon_ce_falls - cb); end
      checks++;
      if (mon_overlap - ob !== 0) begin failures++; $display("FAIL word_write_overlap: dq_oe with oe_n low in %0d cycles expected 0", mon_overlap - ob); end
   endtask

   task automatic test_word_read;
      int lat; logic [31:0] rd; logic e;
      int db;
      db = mon_dq_oe;
      do_xfer(1'b0, 2'b11, 32'h9010, 32'h0, lat, rd, e);
      checks++;
      if (rd !== 32'hA1B2C3D4) begin failures++; $display("FAIL word_read_data: got %h expected a1b2c3d4", rd); end
      checks++;
      if (lat !== 17 || e !== 1'b0) begin failures++; $display("FAIL word_read_timing: lat=%0d err=%b expected 17/0", lat, e); end
      checks++;
      if (mon_dq_oe - db !== 0) begin failures++; $display("FAIL word_read_dq_oe: dq_oe cycles=%0d expected 0", mon_dq_oe - db); end
   endtask

   task automatic test_byte_read;
      int lat; logic [31:0] rd; logic e;
      int db;
      db = mon_dq_oe;
      do_xfer(1'b0, 2'b00, 32'h9005, 32'hFFFF_FFFF, lat, rd, e);
      checks++;
      if (rd !== 32'h0000008F) begin failures++; $display("FAIL byte_read_data: got %h expected 0000008f", rd); end
      checks++;
      if (lat !== 5) begin failures++; $display("FAIL byte_read_latency: got %0d expected 5", lat); end
      checks++;
      if (mon_dq_oe - db !== 0) begin failures++; $display("FAIL byte_read_dq_oe: dq_oe cycles=%0d expected 0", mon_dq_oe - db); end
   endtask

   task automatic test_wrap_read;
      int lat; logic [31:0] rd; logic e;
      int rb;
      rb = rd_addr_q.size();
      do_xfer(1'b0, 2'b01, 32'h28FFF, 32'h0, lat, rd, e);
      checks++;
      if (rd !== 32'h00007E3C) begin failures++; $display("FAIL wrap_read_data: got %h expected 00007e3c", rd); end
      checks++;
      if (e !== 1'b0 || lat !== 9) begin failures++; $display("FAIL wrap_read_timing: err=%b lat=%0d expected 0/9", e, lat); end
      checks++;
      if (rd_addr_q.size() - rb !== 2) begin
         failures++; $display("FAIL wrap_read_strobes: oe_n pulses=%0d expected 2", rd_addr_q.size() - rb);
      end else if (rd_addr_q[rb] !== 32'h1FFFF || rd_addr_q[rb+1] !== 32'h0) begin
         failures++; $display("FAIL wrap_read_strobes: addrs %h,%h expected 1ffff,00000", rd_addr_q[rb], rd_addr_q[rb+1]);
      end
   endtask

   task automatic test_out_of_range;
      int lat; logic [31:0] rd; logic e;
      int cb, pb;
      logic [31:0] bad [3];
      bad[0] = 32'h4000; bad[1] = 32'h29000; bad[2] = 32'h8FFF;
      for (int i = 0; i < 3; i++) begin
         cb = mon_ce_falls; pb = mon_we_pulses;
         do_xfer(i == 2, 2'b10, bad[i], 32'h12345678, lat, rd, e);
         checks++;
         if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL oor_%h_done_err: lat=%0d err=%b expected 1/1", bad[i], lat, e); end
         checks++;
         if (rd !== 32'h0) begin failures++; $display("FAIL oor_%h_read_data: got %h expected 00000000", bad[i], rd); end
         checks++;
         if (mon_ce_falls - cb !== 0 || mon_we_pulses - pb !== 0) begin
            failures++; $display("FAIL oor_%h_pins: ce_n falls=%0d we_n pulses=%0d expected 0/0", bad[i], mon_ce_falls - cb, mon_we_pulses - pb);
         end
      end
   endtask

   task automatic test_trigger_held;
      int db, cb;
      db = mon_done; cb = mon_ce_falls;
      @(negedge clk);
      bus.trigger = 1'b1; bus.we = 1'b0; bus.data_width = 2'b10; bus.addr = 32'h9040;
      repeat (20) @(negedge clk);
      bus.trigger = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (mon_done - db !== 1) begin failures++; $display("FAIL trigger_held_done: done pulses=%0d expected 1", mon_done - db); end
      checks++;
      if (mon_ce_falls - cb !== 1) begin failures++; $display("FAIL trigger_held_xfers: ce_n falls=%0d expected 1", mon_ce_falls - cb); end
   endtask

   task automatic test_done_retrigger;
      int lat; logic [31:0] rd; logic e;
      int cb;
      logic busy_seen;
      cb = mon_ce_falls;
      do_xfer(1'b0, 2'b00, 32'h9005, 32'h0, lat, rd, e);
      bus.trigger = 1'b1;               // raised during the DONE cycle only
      @(negedge clk);
      bus.trigger = 1'b0;
      busy_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         busy_seen = busy_seen | bus.busy;
      end
      #1;
      checks++;
      if (busy_seen !== 1'b0 || mon_ce_falls - cb !== 1) begin
         failures++; $display("FAIL done_trigger_ignored: busy_seen=%b ce_n falls=%0d expected 0/1", busy_seen, mon_ce_falls - cb);
      end
      do_xfer(1'b0, 2'b00, 32'h9005, 32'h0, lat, rd, e);
      checks++;
      if (lat !== 5 || rd !== 32'h8F) begin failures++; $display("FAIL idle_retrigger: lat=%0d data=%h expected 5/0000008f", lat, rd); end
   endtask

   task automatic test_reset_mid_transfer;
      int lat; logic [31:0] rd; logic e;
      int pulses, pb;
      logic prev, found;
      @(negedge clk);
      bus.trigger = 1'b1; bus.we = 1'b1; bus.data_width = 2'b10;
      bus.addr = 32'h9030; bus.write_data = 32'h11223344;
      pulses = 0; prev = 1'b1; found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         bus.trigger = 1'b0;
         if (prev && !sram_we_n) pulses++;
         prev = sram_we_n;
         if (pulses == 2) begin found = 1'b1; break; end
      end
      checks++;
      if (found !== 1'b1) begin failures++; $display("FAIL reset_mid_reach_strobe: second we_n pulse seen=%b expected 1", found); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, bus.busy} !== 5'b11100) begin
         failures++; $display("FAIL reset_mid_async: we_n/ce_n/oe_n/dq_oe/busy=%b expected 11100", {sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, bus.busy});
      end
      pb = mon_we_pulses;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (mon_we_pulses - pb !== 0) begin failures++; $display("FAIL reset_mid_no_strobes: we_n pulses=%0d expected 0", mon_we_pulses - pb); end
      do_xfer(1'b0, 2'b00, 32'h9010, 32'h0, lat, rd, e);
      checks++;
      if (lat !== 5 || rd !== 32'hD4 || e !== 1'b0) begin
         failures++; $display("FAIL reset_mid_recover: lat=%0d data=%h err=%b expected 5/000000d4/0", lat, rd, e);
      end
   endtask

   initial begin
      bus.trigger    = 1'b0;
      bus.we         = 1'b0;
      bus.data_width = 2'b00;
      bus.addr       = 32'h0;
      bus.write_data = 32'h0;
      test_reset;
      test_word_write;
      test_word_read;
      test_byte_read;
      test_wrap_read;
      test_out_of_range;
      test_trigger_held;
      test_done_retrigger;
      test_reset_mid_transfer;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
